ddr_app_responder: RTL and testbench

// Synthesizable responder for the DDR controller app_* user interface: accepts commands and write data,

---
 rtl/ddr_app_responder_if.sv | 39 +++
 rtl/ddr_app_responder.sv | 178 +++++++++++++++++
 tb/tb_ddr_app_responder.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_app_responder_if.sv
// DDR controller app_* user-interface bundle: command, write-data and read-return channels.
// Latency: none, wires only.
// Backpressure: app_rdy / app_wdf_rdy from the slave; the read return has no backpressure.
// Ports (master = traffic source, slave = controller):
//   app_addr/app_cmd/app_en -> app_rdy                       command channel
//   app_wdf_data/mask/wren/end -> app_wdf_rdy               write-data channel
//   app_rd_data/app_rd_data_valid/app_rd_data_end <-        read return
interface ddr_app_responder_if #(
  parameter int ADW = 64,
  parameter int AAW = 32,
  parameter int AMW = ADW / 8
);
  logic [AAW-1:0] app_addr;
  logic [2:0]     app_cmd;
  logic           app_en;
  logic           app_rdy;
  logic [ADW-1:0] app_wdf_data;
  logic [AMW-1:0] app_wdf_mask;
  logic           app_wdf_wren;
  logic           app_wdf_end;
  logic           app_wdf_rdy;
  logic [ADW-1:0] app_rd_data;
  logic           app_rd_data_valid;
  logic           app_rd_data_end;

  modport master (
    output app_addr, app_cmd, app_en,
    output app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy,
    input  app_rd_data, app_rd_data_valid, app_rd_data_end
  );

  modport slave (
    input  app_addr, app_cmd, app_en,
    input  app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy,
    output app_rd_data, app_rd_data_valid, app_rd_data_end
  );
endinterface

// File: rtl/ddr_app_responder.sv
// DDR app_* controller stand-in: queues commands and write beats, executes one command per cycle
// in order against an internal word memory. Latency: read data RD_LATENCY cycles after execute.
// Backpressure: app_rdy / app_wdf_rdy drop while calibrating, on a full queue, or when stalled.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   stall_cmd, stall_wdf          force app_rdy / app_wdf_rdy low
//   init_calib_complete           high CALIB_CYCLES cycles after reset release, sticky
//   err_unknown_cmd               sticky, an illegal command reached the executor
//   app                           app_* bundle, slave side
module ddr_app_responder #(
  parameter int APP_DATA_WIDTH = 64,
  parameter int APP_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH      = 256,
  parameter int CMD_FIFO_DEPTH = 4,
  parameter int WDF_FIFO_DEPTH = 4,
  parameter int RD_LATENCY     = 4,
  parameter int CALIB_CYCLES   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_cmd,
  input  logic               stall_wdf,
  output logic               init_calib_complete,
  output logic               err_unknown_cmd,
  ddr_app_responder_if.slave app
);
  localparam int AMW    = APP_DATA_WIDTH / 8;
  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam int ALSB   = $clog2(AMW);
  localparam int CAW    = $clog2(CMD_FIFO_DEPTH);
  localparam int CCW    = CAW + 1;
  localparam int WAW    = $clog2(WDF_FIFO_DEPTH);
  localparam int WCW    = WAW + 1;
  localparam int CLW    = $clog2(CALIB_CYCLES + 1);

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  // ---------------- calibration ----------------
  logic [CLW-1:0] r_calib_cnt;
  logic           r_calib;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_calib_cnt <= '0;
      r_calib     <= 1'b0;
    end else if (!r_calib) begin
      r_calib_cnt <= r_calib_cnt + CLW'(1);
      if (r_calib_cnt == CLW'(CALIB_CYCLES - 1)) r_calib <= 1'b1;
    end
  end

  assign init_calib_complete = r_calib;

  // ---------------- command queue ----------------
  // Only the word index is stored; the rest of the byte address is never looked at.
  logic [2:0]        r_cmd_op  [CMD_FIFO_DEPTH];
  logic [MEM_AW-1:0] r_cmd_idx [CMD_FIFO_DEPTH];
  logic [CAW-1:0]    r_cmd_wp, r_cmd_rp;
  logic [CCW-1:0]    r_cmd_cnt;
  logic              w_cmd_full, w_cmd_empty, w_cmd_push, w_cmd_pop;

  // Full/empty come from registered occupancy, so a full queue never takes a push even when
  // the head leaves in the same cycle; it reopens one cycle later.
  assign w_cmd_full  = (r_cmd_cnt == CCW'(CMD_FIFO_DEPTH));
  assign w_cmd_empty = (r_cmd_cnt == '0);
  assign app.app_rdy = r_calib & ~w_cmd_full & ~stall_cmd;
  assign w_cmd_push  = app.app_en & app.app_rdy;

  always_ff @(posedge clk) begin
    if (w_cmd_push) begin
      r_cmd_op[r_cmd_wp]  <= app.app_cmd;
      r_cmd_idx[r_cmd_wp] <= app.app_addr[ALSB +: MEM_AW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_wp  <= '0;
      r_cmd_rp  <= '0;
      r_cmd_cnt <= '0;
    end else begin
      if (w_cmd_push) r_cmd_wp <= r_cmd_wp + CAW'(1);
      if (w_cmd_pop)  r_cmd_rp <= r_cmd_rp + CAW'(1);
      r_cmd_cnt <= r_cmd_cnt + CCW'(w_cmd_push) - CCW'(w_cmd_pop);
    end
  end

  // ---------------- write-data queue ----------------
  logic [APP_DATA_WIDTH-1:0] r_wdf_data [WDF_FIFO_DEPTH];
  logic [AMW-1:0]            r_wdf_mask [WDF_FIFO_DEPTH];
  logic [WAW-1:0]            r_wdf_wp, r_wdf_rp;
  logic [WCW-1:0]            r_wdf_cnt;
  logic                      w_wdf_full, w_wdf_empty, w_wdf_push, w_wdf_pop;

  assign w_wdf_full      = (r_wdf_cnt == WCW'(WDF_FIFO_DEPTH));
  assign w_wdf_empty     = (r_wdf_cnt == '0);
  assign app.app_wdf_rdy = r_calib & ~w_wdf_full & ~stall_wdf;
  assign w_wdf_push      = app.app_wdf_wren & app.app_wdf_rdy;

  always_ff @(posedge clk) begin
    if (w_wdf_push) begin
      r_wdf_data[r_wdf_wp] <= app.app_wdf_data;
      r_wdf_mask[r_wdf_wp] <= app.app_wdf_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdf_wp  <= '0;
      r_wdf_rp  <= '0;
      r_wdf_cnt <= '0;
    end else begin
      if (w_wdf_push) r_wdf_wp <= r_wdf_wp + WAW'(1);
      if (w_wdf_pop)  r_wdf_rp <= r_wdf_rp + WAW'(1);
      r_wdf_cnt <= r_wdf_cnt + WCW'(w_wdf_push) - WCW'(w_wdf_pop);
    end
  end

  // ---------------- executor ----------------
  logic [2:0]        w_head_op;
  logic [MEM_AW-1:0] w_head_idx;
  logic              w_is_wr, w_is_rd, w_is_bad, w_do_wr;

  assign w_head_op  = r_cmd_op[r_cmd_rp];
  assign w_head_idx = r_cmd_idx[r_cmd_rp];
  assign w_is_wr    = ~w_cmd_empty & (w_head_op == CMD_WR);
  assign w_is_rd    = ~w_cmd_empty & (w_head_op == CMD_RD);
  assign w_is_bad   = ~w_cmd_empty & ~(w_head_op == CMD_WR) & ~(w_head_op == CMD_RD);
  // A write at the head waits for its beat and holds back everything queued behind it.
  assign w_do_wr    = w_is_wr & ~w_wdf_empty;
  assign w_cmd_pop  = w_do_wr | w_is_rd | w_is_bad;
  assign w_wdf_pop  = w_do_wr;

  // Memory is deliberately not cleared by reset; a write executing on the reset edge is dropped.
  logic [APP_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (w_do_wr && !rst) begin
      for (int i = 0; i < AMW; i++) begin
        if (!r_wdf_mask[r_wdf_rp][i]) r_mem[w_head_idx][8*i +: 8] <= r_wdf_data[r_wdf_rp][8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           err_unknown_cmd <= 1'b0;
    else if (w_is_bad) err_unknown_cmd <= 1'b1;
  end

  // ---------------- read return pipe ----------------
  // Stage 0 captures the memory word in the execute cycle; the last stage drives the outputs.
  logic [RD_LATENCY-1:0]     r_pipe_vld;
  logic [APP_DATA_WIDTH-1:0] r_pipe_dat [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_pipe_dat[i] <= '0;
    end else begin
      r_pipe_vld[0] <= w_is_rd;
      r_pipe_dat[0] <= r_mem[w_head_idx];
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_dat[i] <= r_pipe_dat[i-1];
      end
    end
  end

  assign app.app_rd_data       = r_pipe_dat[RD_LATENCY-1];
  assign app.app_rd_data_valid = r_pipe_vld[RD_LATENCY-1];
  assign app.app_rd_data_end   = r_pipe_vld[RD_LATENCY-1];

  // app_wdf_end carries no information for single-beat transfers; address bits outside the
  // word index wrap away.
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, app.app_wdf_end, app.app_addr};
endmodule

// File: tb/tb_ddr_app_responder.sv
module tb_ddr_app_responder;
  localparam int ADW   = 64;
  localparam int AAW   = 32;
  localparam int DEPTH = 256;
  localparam int LAT   = 4;
  localparam int CAL   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall_cmd = 1'b0;
  logic stall_wdf = 1'b0;
  logic calib, err;

  ddr_app_responder_if #(.ADW(ADW), .AAW(AAW)) bus ();

  ddr_app_responder #(
    .APP_DATA_WIDTH(ADW), .APP_ADDR_WIDTH(AAW), .MEM_DEPTH(DEPTH),
    .CMD_FIFO_DEPTH(4), .WDF_FIFO_DEPTH(4), .RD_LATENCY(LAT), .CALIB_CYCLES(CAL)
  ) dut (
    .clk(clk), .rst(rst), .stall_cmd(stall_cmd), .stall_wdf(stall_wdf),
    .init_calib_complete(calib), .err_unknown_cmd(err), .app(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [2:0] op; logic [31:0] addr; } cmd_t;
  typedef struct { logic [63:0] d; logic [7:0] m; } beat_t;
  typedef struct { logic [63:0] d; logic [63:0] k; } exp_t;

  cmd_t  cq[$];
  beat_t bq[$];
  exp_t  eq[$];
  logic [63:0] mmem   [DEPTH];
  logic [63:0] mknown [DEPTH];
  bit    err_model = 0;

  int    cyc = 0;
  int    ncal = 0;
  bit    rst_s = 1;
  bit    started = 0;
  int    vcnt = 0;
  int    last_vcyc = 0;
  logic [63:0] last_vdat = '0;
  int    acc_cyc = 0;

  // Commands resolve in queue order as soon as their data is known; timing is irrelevant to
  // the values a read must return.
  task automatic resolve();
    cmd_t h; beat_t b; exp_t e; int idx;
    while (cq.size() > 0) begin
      h = cq[0];
      idx = int'(h.addr / 8) % DEPTH;
      if (h.op == 3'd0) begin
        if (bq.size() == 0) break;
        b = bq.pop_front();
        for (int i = 0; i < 8; i++) begin
          if (!b.m[i]) begin
            mmem[idx][8*i +: 8]   = b.d[8*i +: 8];
            mknown[idx][8*i +: 8] = 8'hFF;
          end
        end
      end else if (h.op == 3'd1) begin
        e.d = mmem[idx];
        e.k = mknown[idx];
        eq.push_back(e);
      end else begin
        err_model = 1;
      end
      void'(cq.pop_front());
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    started = 1;
    rst_s = rst;
    if (rst) ncal = 0; else ncal++;
  end

  // Single compare process: outputs checked first, then this cycle's handshakes enter the model.
  always @(negedge clk) begin
    exp_t e; cmd_t c; beat_t b;
    if (started) begin
      if (rst_s) begin
        chk("rst_calib", calib, 0);
        chk("rst_app_rdy", bus.app_rdy, 0);
        chk("rst_wdf_rdy", bus.app_wdf_rdy, 0);
        chk("rst_rd_valid", bus.app_rd_data_valid, 0);
        chk("rst_rd_end", bus.app_rd_data_end, 0);
        chk("rst_rd_data", bus.app_rd_data, 0);
        chk("rst_err", err, 0);
      end else begin
        chk("calib", calib, ncal >= CAL);
        if (ncal < CAL || stall_cmd) chk("app_rdy_gated", bus.app_rdy, 0);
        if (ncal < CAL || stall_wdf) chk("wdf_rdy_gated", bus.app_wdf_rdy, 0);
        chk("rd_end_eq_valid", bus.app_rd_data_end, bus.app_rd_data_valid);
        if (!err_model) chk("err_unknown_cmd", err, 0);
        if (bus.app_rd_data_valid) begin
          vcnt++;
          last_vcyc = cyc;
          last_vdat = bus.app_rd_data;
          if (eq.size() == 0) chk("unexpected_rd_valid", bus.app_rd_data_valid, 0);
          else begin
            e = eq.pop_front();
            chk("rd_data", bus.app_rd_data & e.k, e.d & e.k);
          end
        end
      end
      if (rst) begin
        cq.delete(); bq.delete(); eq.delete();
        err_model = 0;
      end else begin
        if (bus.app_en && bus.app_rdy) begin
          c.op = bus.app_cmd; c.addr = bus.app_addr; cq.push_back(c);
        end
        if (bus.app_wdf_wren && bus.app_wdf_rdy) begin
          b.d = bus.app_wdf_data; b.m = bus.app_wdf_mask; bq.push_back(b);
        end
        resolve();
      end
    end
  end

  // ---------------- drivers (called at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [31:0] a);
    bit acc; int t;
    acc = 0; t = 0;
    bus.app_cmd = op; bus.app_addr = a; bus.app_en = 1'b1;
    while (!acc && t < 200) begin
      @(negedge clk); acc = bus.app_rdy && !rst;
      @(posedge clk); #1; t++;
    end
    bus.app_en = 1'b0;
    acc_cyc = cyc;
    chk("cmd_accept", acc, 1);
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] m);
    bit acc; int t;
    acc = 0; t = 0;
    bus.app_wdf_data = d; bus.app_wdf_mask = m; bus.app_wdf_wren = 1'b1; bus.app_wdf_end = 1'b1;
    while (!acc && t < 200) begin
      @(negedge clk); acc = bus.app_wdf_rdy && !rst;
      @(posedge clk); #1; t++;
    end
    bus.app_wdf_wren = 1'b0; bus.app_wdf_end = 1'b0;
    chk("beat_accept", acc, 1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
    fork
      send_cmd(3'd0, a);
      send_beat(d, m);
    join
  endtask

  task automatic do_read(input logic [31:0] a, output logic [63:0] d, output int lat);
    int v0, t, a_cyc;
    v0 = vcnt;
    send_cmd(3'd1, a);
    a_cyc = acc_cyc;
    t = 0;
    while (vcnt == v0 && t < 100) begin @(posedge clk); #1; t++; end
    chk("rd_returned", vcnt - v0, 1);
    d = last_vdat;
    lat = last_vcyc - a_cyc;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((eq.size() > 0 || cq.size() > 0) && t < 400) begin @(posedge clk); #1; t++; end
    chk("drain", eq.size() + cq.size(), 0);
    idle(LAT + 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [63:0] d;
  int lat, rel_cyc, v0, nacc, ri;
  logic [31:0] rd_addrs [5];
  logic [2:0]  r_op  [120];
  logic [31:0] r_adr [120];
  int nw;

  initial begin
    bus.app_addr = '0; bus.app_cmd = '0; bus.app_en = 0;
    bus.app_wdf_data = '0; bus.app_wdf_mask = '0; bus.app_wdf_wren = 0; bus.app_wdf_end = 0;
    for (int i = 0; i < DEPTH; i++) begin mmem[i] = '0; mknown[i] = '0; end

    // 1: reset 3 cycles, calibration timing
    repeat (3) @(posedge clk);
    #1; rst = 0; rel_cyc = cyc;
    begin
      int t; t = 0;
      while (!calib && t < 60) begin @(negedge clk); t++; end
    end
    chk("calib_latency", cyc - rel_cyc, 16);
    chk("app_rdy_after_calib", bus.app_rdy, 1);
    chk("wdf_rdy_after_calib", bus.app_wdf_rdy, 1);
    @(posedge clk); #1;

    // 2: write then read, latency
    wr(32'h40, 64'hDEADBEEF_01234567, 8'h00);
    do_read(32'h40, d, lat);
    chk("t2_data", d, 64'hDEADBEEF_01234567);
    chk("t2_latency", lat, LAT);

    // 3: beat leads command, command leads beat (read queued behind blocked write)
    send_beat(64'hA5A5_0000_1234_5678, 8'h00);
    idle(5);
    send_cmd(3'd0, 32'h100);
    do_read(32'h100, d, lat);
    chk("t3_beat_first", d, 64'hA5A5_0000_1234_5678);
    send_cmd(3'd0, 32'h108);
    fork
      do_read(32'h108, d, lat);
      begin idle(4); send_beat(64'h0F0F_F0F0_CAFE_BABE, 8'h00); end
    join
    chk("t3_cmd_first", d, 64'h0F0F_F0F0_CAFE_BABE);

    // 4: byte mask and address wrap
    wr(32'h000, 64'h1111_1111_1111_1111, 8'h00);
    wr(32'h000, 64'h2222_2222_2222_2222, 8'hF0);
    do_read(32'h000, d, lat);
    chk("t4_mask", d, 64'h11111111_22222222);
    do_read(32'h800, d, lat);
    chk("t4_alias_800", d, 64'h11111111_22222222);
    do_read(32'h805, d, lat);
    chk("t4_alias_805", d, 64'h11111111_22222222);

    // 5: stall hooks, full command queue, in-order return
    stall_cmd = 1; stall_wdf = 1;
    idle(3);
    @(negedge clk);
    chk("t5_stall_cmd_rdy", bus.app_rdy, 0);
    chk("t5_stall_wdf_rdy", bus.app_wdf_rdy, 0);
    @(posedge clk); #1;
    stall_cmd = 0;
    send_cmd(3'd0, 32'h200);
    rd_addrs[0] = 32'h200; rd_addrs[1] = 32'h100; rd_addrs[2] = 32'h108;
    rd_addrs[3] = 32'h000; rd_addrs[4] = 32'h040;
    v0 = vcnt; nacc = 0;
    bus.app_cmd = 3'd1; bus.app_en = 1;
    for (int k = 0; k < 8; k++) begin
      bus.app_addr = rd_addrs[nacc];
      @(negedge clk);
      if (bus.app_rdy) nacc++;
      @(posedge clk); #1;
    end
    bus.app_en = 0;
    chk("t5_accepts_until_full", nacc + 1, 4);
    stall_wdf = 0;
    fork
      send_beat(64'h5555_6666_7777_8888, 8'h00);
      begin
        for (int k = 3; k < 5; k++) send_cmd(3'd1, rd_addrs[k]);
      end
    join
    wait_drain();
    chk("t5_valid_count", vcnt - v0, 5);

    // 6: illegal command consumes no beat; sticky error; reset drops reads
    v0 = vcnt;
    send_beat(64'h0123_4567_89AB_CDEF, 8'h00);
    send_cmd(3'b010, 32'h40);
    idle(LAT + 4);
    chk("t6_err_set", err, 1);
    chk("t6_no_valid", vcnt - v0, 0);
    send_cmd(3'd0, 32'h48);
    do_read(32'h48, d, lat);
    chk("t6_beat_kept", d, 64'h0123_4567_89AB_CDEF);
    chk("t6_err_sticky", err, 1);
    for (int k = 0; k < 8; k++) send_cmd(3'd1, 32'h48);
    rst = 1;
    @(posedge clk); #1;
    v0 = vcnt;
    idle(2);
    rst = 0;
    idle(40);
    chk("t6_no_valid_after_rst", vcnt - v0, 0);
    chk("t6_err_cleared", err, 0);

    // random traffic: independent command and beat streams with random stalls
    nw = 0;
    for (int i = 0; i < 120; i++) begin
      int r; logic [31:0] a;
      r = $urandom_range(0, 9);
      r_op[i] = (r < 4) ? 3'd0 : (r < 9) ? 3'd1 : 3'($urandom_range(2, 7));
      if (r_op[i] == 3'd0) nw++;
      a = $urandom;
      a[10:3] = 8'($urandom_range(0, 15));
      r_adr[i] = a;
    end
    v0 = vcnt;
    fork
      begin
        for (int i = 0; i < 120; i++) begin
          if ($urandom_range(0, 3) == 0) begin stall_cmd = 1; idle($urandom_range(1, 3)); stall_cmd = 0; end
          idle($urandom_range(0, 2));
          send_cmd(r_op[i], r_adr[i]);
        end
      end
      begin
        for (int j = 0; j < nw; j++) begin
          if ($urandom_range(0, 3) == 0) begin stall_wdf = 1; idle($urandom_range(1, 3)); stall_wdf = 0; end
          idle($urandom_range(0, 3));
          send_beat({$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
        end
      end
    join
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
